// File: rtl/rsa_pkg.sv
// Shared types and default widths for the RSA modular arithmetic datapath.
// The reduction FSM state type lives here so that neighbouring blocks can decode it.
package rsa_pkg;

    localparam int DEN_W_DEFAULT = 32;
    localparam int NUM_W_DEFAULT = 2 * DEN_W_DEFAULT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } modred_state_t;

endpackage

// File: rtl/modred_step.sv
// One restoring-division step: shift a numerator bit into the remainder and
// subtract the denominator when the shifted value reaches it.
module modred_step #(
    parameter int DEN_W = 32
) (
    input  logic [DEN_W:0]   rem,
    input  logic             bit_in,
    input  logic [DEN_W-1:0] den,
    output logic [DEN_W:0]   rem_next
);

    // One spare bit on top so the shift never loses information even if rem were full width.
    logic [DEN_W+1:0] shifted;
    logic             ge;

    always_comb begin
        shifted  = {rem, bit_in};
        ge       = (shifted >= {2'b00, den});
        rem_next = ge ? (DEN_W+1)'(shifted - {2'b00, den}) : (DEN_W+1)'(shifted);
    end

endmodule

// File: rtl/modular_reduce_seq.sv
// Sequential numerator mod denominator: one restoring step per clock, MSB first,
// NUM_W cycles per reduction, with a divide-by-zero short cut straight to DONE.
module modular_reduce_seq
    import rsa_pkg::*;
#(
    parameter int DEN_W = DEN_W_DEFAULT,
    parameter int NUM_W = NUM_W_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] denominator,
    output logic             busy,
    output logic             modular_done,
    output logic [DEN_W-1:0] result,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(NUM_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_W - 1);

    modred_state_t    state, state_next;
    logic [NUM_W-1:0] num_q;
    logic [DEN_W-1:0] den_q;
    logic [DEN_W:0]   rem;
    logic [DEN_W:0]   rem_next;
    logic [CNT_W-1:0] cnt;
    logic             den_zero;

    assign den_zero = (denominator == '0);

    modred_step #(
        .DEN_W (DEN_W)
    ) u_step (
        .rem      (rem),
        .bit_in   (num_q[cnt]),
        .den      (den_q),
        .rem_next (rem_next)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = den_zero ? DONE : REDUCE;
                end
            end
            REDUCE: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured only on the accepting edge; REDUCE ignores the input bus.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            num_q       <= '0;
            den_q       <= '0;
            rem         <= '0;
            cnt         <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (den_zero) begin
                            result      <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            num_q       <= numerator;
                            den_q       <= denominator;
                            rem         <= '0;
                            cnt         <= CNT_LAST;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                REDUCE: begin
                    rem <= rem_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result <= rem_next[DEN_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state == REDUCE);
    assign modular_done = (state == DONE);

endmodule

// File: tb/tb_modular_reduce_seq.sv
// Directed bench for modular_reduce_seq: a table of reductions with hand-computed
// remainders, plus reset-abort and held-start sequences.
module tb_modular_reduce_seq;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [63:0] numerator;
    logic [31:0] denominator;
    logic        busy;
    logic        modular_done;
    logic [31:0] result;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    modular_reduce_seq #(
        .DEN_W (32),
        .NUM_W (64)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .numerator    (numerator),
        .denominator  (denominator),
        .busy         (busy),
        .modular_done (modular_done),
        .result       (result),
        .div_by_zero  (div_by_zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [63:0] num;
        logic [31:0] den;
        logic [31:0] res;
        logic        dbz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Raise start with the given operands and wait for modular_done; leaves start high.
    task automatic run_op(input string name, input logic [63:0] num, input logic [31:0] den,
                          input logic [31:0] res, input logic dbz);
        int edges;
        int busy_cnt;
        int exp_lat;
        edges    = 0;
        busy_cnt = 0;
        exp_lat  = dbz ? 0 : 64;
        numerator   = num;
        denominator = den;
        start       = 1'b1;
        while (1) begin
            @(posedge Clk);
            #1;
            // Scramble the input bus once the operands have been taken.
            numerator   = {$urandom, $urandom};
            denominator = $urandom;
            if (busy) busy_cnt++;
            if (modular_done) break;
            edges++;
            if (edges > 200) break;
        end
        check({name, " latency"}, 64'(edges), 64'(exp_lat));
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        check({name, " result"}, 64'(result), 64'(res));
        check({name, " div_by_zero"}, 64'(div_by_zero), 64'(dbz));
        check({name, " busy_in_done"}, 64'(busy), 64'd0);
    endtask

    task automatic drop_start(input string name, input logic [31:0] res);
        start = 1'b0;
        @(posedge Clk);
        #1;
        check({name, " done_cleared"}, 64'(modular_done), 64'd0);
        check({name, " result_held"}, 64'(result), 64'(res));
    endtask

    initial begin
        vecs[0] = '{num: 64'd100,                   den: 32'd7,           res: 32'd2,          dbz: 1'b0};
        vecs[1] = '{num: 64'hFFFF_FFFF_FFFF_FFFF,   den: 32'hFFFF_FFFF,   res: 32'd0,          dbz: 1'b0};
        vecs[2] = '{num: 64'hFFFF_FFFF_FFFF_FFFF,   den: 32'hFFFF_FFFE,   res: 32'd3,          dbz: 1'b0};
        vecs[3] = '{num: 64'd5,                     den: 32'd9,           res: 32'd5,          dbz: 1'b0};
        vecs[4] = '{num: 64'd1234,                  den: 32'd0,           res: 32'd0,          dbz: 1'b1};
        vecs[5] = '{num: 64'd12345678,              den: 32'd1000,        res: 32'd678,        dbz: 1'b0};
        vecs[6] = '{num: 64'h1_0000_0000,           den: 32'd3,           res: 32'd1,          dbz: 1'b0};
        vecs[7] = '{num: 64'd0,                     den: 32'd5,           res: 32'd0,          dbz: 1'b0};
        vecs[8] = '{num: 64'h8000_0000_0000_0000,   den: 32'hFFFF_FFFF,   res: 32'h8000_0000,  dbz: 1'b0};
        vecs[9] = '{num: 64'hDEAD_BEEF_0000_0001,   den: 32'd1,           res: 32'd0,          dbz: 1'b0};

        Reset       = 1'b1;
        start       = 1'b0;
        numerator   = '0;
        denominator = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(modular_done), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset dbz", 64'(div_by_zero), 64'd0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].num, vecs[i].den, vecs[i].res, vecs[i].dbz);
            drop_start($sformatf("vec%0d", i), vecs[i].res);
        end

        // Abort mid-REDUCE with an asynchronous reset pulse.
        run_op("pre_abort", 64'd100, 32'd7, 32'd2, 1'b0);
        drop_start("pre_abort", 32'd2);
        numerator   = 64'hFFFF_FFFF_FFFF_FFFF;
        denominator = 32'hFFFF_FFFE;
        start       = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge Clk);
        #2;
        check("abort busy_before", 64'(busy), 64'd1);
        Reset = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(modular_done), 64'd0);
        check("abort result", 64'(result), 64'd0);
        check("abort dbz", 64'(div_by_zero), 64'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        run_op("after_abort", 64'd1000, 32'd33, 32'd10, 1'b0);

        // Start stays high past done with new operands: no restart allowed.
        numerator   = 64'd50;
        denominator = 32'd6;
        for (int k = 0; k < 10; k++) begin
            @(posedge Clk);
            #1;
            numerator   = 64'd50;
            denominator = 32'd6;
            check($sformatf("hold%0d done", k), 64'(modular_done), 64'd1);
            check($sformatf("hold%0d busy", k), 64'(busy), 64'd0);
            check($sformatf("hold%0d result", k), 64'(result), 64'd10);
        end
        drop_start("hold", 32'd10);
        run_op("restart", 64'd50, 32'd6, 32'd2, 1'b0);
        drop_start("restart", 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
